// File: rtl/shift_register_pkg.sv
// shift_register_pkg
// Shared definitions for the serial shift-register chain and its loader.
//   CHAIN_LEN      : number of stages in the serial chain; also the default
//                    frame width of the loader.
//   loader_state_t : loader FSM state encoding (IDLE, SHIFT, GAP).
package shift_register_pkg;

    localparam int CHAIN_LEN = 124;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/shift_register_loader_if.sv
// shift_register_loader_if
// Bundles the parallel load handshake and the serial output side of the loader.
//   load_data    : parallel frame word, bit 0 is transmitted first
//   load_valid   : load_data is valid
//   load_ready   : loader can accept a word this cycle
//   serial_out   : registered serial bit towards the chain's data_in
//   frame_active : serial_out currently presents a frame bit
//   frame_done   : one-cycle pulse coincident with the last frame bit
// Handshake: a word transfers on every rising edge where load_valid and
// load_ready are both high. The source must hold load_data stable while
// load_valid is high and no transfer has happened; load_ready never depends
// on load_valid.
// master = frame source, slave = loader.
interface shift_register_loader_if
    import shift_register_pkg::*;
#(
    parameter int WIDTH = CHAIN_LEN
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             frame_active;
    logic             frame_done;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  frame_active,
        input  frame_done
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output serial_out,
        output frame_active,
        output frame_done
    );
endinterface

// File: rtl/shift_register_loader.sv
// shift_register_loader
// Parallel-to-serial transmitter feeding the serial shift-register chain.
// Accepts one WIDTH-bit word per handshake and shifts it out LSB first, one
// bit per clock, optionally followed by GAP_CYCLES idle cycles.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high; discards any in-flight frame
//   bus       : slave side of shift_register_loader_if (load handshake and
//               serial_out / frame_active / frame_done)
//   state_dbg : current FSM state, for observation only
module shift_register_loader
    import shift_register_pkg::*;
#(
    parameter int   WIDTH      = CHAIN_LEN,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    shift_register_loader_if.slave  bus,
    output loader_state_t           state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    loader_state_t    state_q,   state_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             active_q,  active_d;
    logic             done_q,    done_d;

    logic last_bit;
    logic load_ready;
    logic accept;

    assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST);
    // Ready comes from state alone: idle, or the final bit of a frame when
    // frames may stream back to back.
    assign load_ready = (state_q == IDLE) || ((GAP_CYCLES == 0) && last_bit);
    assign accept     = bus.load_valid && load_ready;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = bus.load_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    shift_d   = bus.load_data;
                    bit_cnt_d = '0;
                end else begin
                    // After WIDTH shifts the register holds only IDLE_LEVEL,
                    // so shift_q[0] doubles as the idle/gap line level.
                    shift_d = {IDLE_LEVEL, shift_q[WIDTH-1:1]};
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Flags are registered from next-state values so they line up with
        // the bit that shift_q[0] presents in the same cycle.
        active_d = (state_d == SHIFT);
        done_d   = (state_d == SHIFT) && (bit_cnt_d == BIT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= {WIDTH{IDLE_LEVEL}};
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign bus.load_ready   = load_ready;
    assign bus.serial_out   = shift_q[0];
    assign bus.frame_active = active_q;
    assign bus.frame_done   = done_q;
    assign state_dbg        = state_q;

endmodule
